// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache and the program counter.
package instruction_cache_pkg;

    // FSM encoding; SENT_INS is also decoded by the program counter.
    typedef enum logic [3:0] {
        START     = 4'd0,
        LOAD_REQ  = 4'd1,
        LOAD_WAIT = 4'd2,
        SENT_INS  = 4'd3
    } ins_cache_state_e;

    // Each instruction occupies one 8-byte slot in DDR.
    localparam int unsigned INS_BYTES = 8;

endpackage

// File: rtl/instruction_cache_ins_buffer.sv
// Page buffer: one synchronous write port, one registered read port.
module instruction_cache_ins_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; storage carries no reset so it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last hit word while not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Page-based instruction cache: fills one page from DDR one word at a time
// and serves the PC from the resident page with a one-cycle read latency.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_MEM  = 16,
    parameter int unsigned ISA_DEPTH       = 64,
    parameter int unsigned TOTAL_ISA_DEPTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH  = 28,
    parameter int unsigned INS_WIDTH       = 32,
    parameter int unsigned ISA_BASE_ADDR   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    input  logic                      ins_inp_valid,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [9:0]                load_times,
    output logic [INS_WIDTH-1:0]      ins_out,
    output logic                      ins_valid,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic                      ddr_rd_ack,
    input  logic [INS_WIDTH-1:0]      ddr_rd_data,
    input  logic                      ddr_rd_data_valid
);

    localparam int unsigned OFF_W = $clog2(ISA_DEPTH);

    localparam logic [DDR_ADDR_WIDTH-1:0] ONE_W   = DDR_ADDR_WIDTH'(1);
    localparam logic [DDR_ADDR_WIDTH-1:0] DEPTH_W = DDR_ADDR_WIDTH'(ISA_DEPTH);
    localparam logic [DDR_ADDR_WIDTH-1:0] TOTAL_W = DDR_ADDR_WIDTH'(TOTAL_ISA_DEPTH);
    localparam logic [DDR_ADDR_WIDTH-1:0] BASE_W  = DDR_ADDR_WIDTH'(ISA_BASE_ADDR);
    localparam logic [DDR_ADDR_WIDTH-1:0] BYTES_W = DDR_ADDR_WIDTH'(INS_BYTES);
    localparam logic [OFF_W-1:0]          LAST_W  = OFF_W'(ISA_DEPTH - 1);

    ins_cache_state_e state_q, state_d;

    logic [OFF_W-1:0]          fill_cnt_q, fill_cnt_d;
    logic [DDR_ADDR_WIDTH-1:0] fill_page_q, fill_page_d;
    logic [9:0]                load_times_q, load_times_d;
    logic                      ins_valid_q;

    logic [DDR_ADDR_WIDTH-1:0] addr_ext;
    logic [DDR_ADDR_WIDTH-1:0] page_base;
    logic [DDR_ADDR_WIDTH-1:0] fill_index;
    logic                      hit;
    logic                      in_range;
    logic                      buf_we;

    // The PC's acceptance strobe only gates its own increment.
    logic unused_ins_inp_valid;
    assign unused_ins_inp_valid = ins_inp_valid;

    // Hit compare against the resident page and DDR address arithmetic.
    always_comb begin
        addr_ext   = DDR_ADDR_WIDTH'(addr_ins);
        page_base  = (DDR_ADDR_WIDTH'(load_times_q) - ONE_W) * DEPTH_W;
        fill_index = fill_page_q * DEPTH_W + DDR_ADDR_WIDTH'(fill_cnt_q);
        in_range   = addr_ext < TOTAL_W;
        // load_times of 0 means nothing resident, so no address can hit.
        hit        = (state_q == SENT_INS) && (load_times_q != '0) &&
                     (addr_ext >= page_base) && (addr_ext < page_base + DEPTH_W);
    end

    // Next-state logic, buffer write strobe and DDR request outputs.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        fill_page_d  = fill_page_q;
        load_times_d = load_times_q;
        buf_we       = 1'b0;
        ddr_rd_req   = 1'b0;
        ddr_rd_addr  = '0;
        unique case (state_q)
            START: begin
                fill_page_d = '0;
                fill_cnt_d  = '0;
                state_d     = LOAD_REQ;
            end
            LOAD_REQ: begin
                ddr_rd_req  = 1'b1;
                ddr_rd_addr = BASE_W + fill_index * BYTES_W;
                if (ddr_rd_ack) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (ddr_rd_data_valid) begin
                    buf_we     = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LAST_W) begin
                        load_times_d = 10'(fill_page_q + ONE_W);
                        state_d      = SENT_INS;
                    end else begin
                        state_d = LOAD_REQ;
                    end
                end
            end
            SENT_INS: begin
                // Out-of-range addresses (pending PC jump) never start a refill.
                if (!hit && in_range) begin
                    fill_page_d = addr_ext / DEPTH_W;
                    fill_cnt_d  = '0;
                    state_d     = LOAD_REQ;
                end
            end
            default: state_d = START;
        endcase
    end

    // State and fill bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= START;
            fill_cnt_q   <= '0;
            fill_page_q  <= '0;
            load_times_q <= '0;
            ins_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_page_q  <= fill_page_d;
            load_times_q <= load_times_d;
            ins_valid_q  <= hit;
        end
    end

    // Page base is a multiple of ISA_DEPTH, so the low index bits are the offset.
    instruction_cache_ins_buffer #(
        .DEPTH  (ISA_DEPTH),
        .WIDTH  (INS_WIDTH),
        .ADDR_W (OFF_W)
    ) u_ins_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_addr (fill_cnt_q),
        .wr_data (ddr_rd_data),
        .rd_en   (hit),
        .rd_addr (addr_ins[OFF_W-1:0]),
        .rd_data (ins_out)
    );

    assign ins_cache_rdy    = hit;
    assign st_cur_ins_cache = state_q;
    assign load_times       = load_times_q;
    assign ins_valid        = ins_valid_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural single-beat DDR model.
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_ins;
    logic        ins_inp_valid;
    logic        ins_cache_rdy;
    logic [3:0]  st_cur_ins_cache;
    logic [9:0]  load_times;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        ddr_rd_req;
    logic [27:0] ddr_rd_addr;
    logic        ddr_rd_ack;
    logic [31:0] ddr_data_resp;
    logic        ddr_dv_resp;
    logic        ddr_dv_spur;

    int ack_max   = 0;
    int data_max  = 0;
    int data_mode = 0;

    logic [27:0] req_log [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_cache dut (
        .clk               (clk),
        .rst               (rst),
        .addr_ins          (addr_ins),
        .ins_inp_valid     (ins_inp_valid),
        .ins_cache_rdy     (ins_cache_rdy),
        .st_cur_ins_cache  (st_cur_ins_cache),
        .load_times        (load_times),
        .ins_out           (ins_out),
        .ins_valid         (ins_valid),
        .ddr_rd_req        (ddr_rd_req),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_ack        (ddr_rd_ack),
        .ddr_rd_data       (ddr_dv_spur ? 32'hDEAD_BEEF : ddr_data_resp),
        .ddr_rd_data_valid (ddr_dv_resp | ddr_dv_spur)
    );

    function automatic logic [31:0] ddr_word(input int unsigned idx, input int mode);
        logic [31:0] w;
        w = idx;
        if (mode != 0) w = (w * 32'h9E37_79B1) ^ 32'h0000_5A5A;
        return w;
    endfunction

    // DDR model: acks after 0..ack_max cycles, returns one beat 0..data_max later.
    initial begin : ddr_model
        int d;
        logic [27:0] a;
        ddr_rd_ack    = 1'b0;
        ddr_dv_resp   = 1'b0;
        ddr_data_resp = '0;
        forever begin
            if (ddr_rd_req === 1'b1) begin
                d = int'($urandom_range(ack_max));
                repeat (d) begin @(posedge clk); #1; end
                if (ddr_rd_req === 1'b1) begin
                    a = ddr_rd_addr;
                    req_log.push_back(a);
                    ddr_rd_ack = 1'b1;
                    @(posedge clk); #1;
                    ddr_rd_ack = 1'b0;
                    d = int'($urandom_range(data_max));
                    repeat (d) begin @(posedge clk); #1; end
                    ddr_data_resp = ddr_word(int'(a >> 3), data_mode);
                    ddr_dv_resp   = 1'b1;
                    @(posedge clk); #1;
                    ddr_dv_resp   = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_state"}, 64'(st_cur_ins_cache), 64'd0);
        chk({tag, "_rdy"},   64'(ins_cache_rdy),    64'd0);
        chk({tag, "_lt"},    64'(load_times),       64'd0);
        chk({tag, "_out"},   64'(ins_out),          64'd0);
        chk({tag, "_valid"}, 64'(ins_valid),        64'd0);
        chk({tag, "_req"},   64'(ddr_rd_req),       64'd0);
        chk({tag, "_addr"},  64'(ddr_rd_addr),      64'd0);
    endtask

    task automatic wait_sent(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (st_cur_ins_cache === 4'd3) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_reach_sent"}, 64'(done), 64'd1);
    endtask

    task automatic check_fill(input string tag, input logic [27:0] base);
        int n;
        n = req_log.size();
        chk({tag, "_req_count"}, 64'(n), 64'd64);
        for (int i = 0; i < n && i < 64; i++) begin
            chk($sformatf("%s_req%0d", tag, i), 64'(req_log[i]), 64'(base + 28'(i * 8)));
        end
    endtask

    initial begin : stimulus
        int bad_req, bad_valid;
        rst           = 1'b0;
        addr_ins      = 16'd0;
        ins_inp_valid = 1'b0;
        ddr_dv_spur   = 1'b0;
        #1 rst = 1'b1;
        #1;
        reset_checks("reset");
        tick(); tick();
        rst = 1'b0;

        // Initial fill of page 0.
        wait_sent("fill0", 2000);
        check_fill("fill0", 28'h000);
        chk("fill0_lt",  64'(load_times),    64'd1);
        chk("fill0_rdy", 64'(ins_cache_rdy), 64'd1);

        // One-cycle read latency.
        ins_inp_valid = 1'b1;
        addr_ins = 16'd5;
        tick();
        chk("rd5_out",   64'(ins_out),   64'd5);
        chk("rd5_valid", 64'(ins_valid), 64'd1);
        addr_ins = 16'd6;
        tick();
        chk("rd6_out",   64'(ins_out),   64'd6);
        chk("rd6_valid", 64'(ins_valid), 64'd1);

        // Page end: combinational miss, then page 1 fill.
        req_log.delete();
        addr_ins = 16'd64;
        #1;
        chk("pgend_rdy_drop", 64'(ins_cache_rdy), 64'd0);
        wait_sent("fill1", 2000);
        check_fill("fill1", 28'h200);
        chk("fill1_lt", 64'(load_times), 64'd2);
        tick();
        chk("rd64_out",   64'(ins_out),   64'd64);
        chk("rd64_valid", 64'(ins_valid), 64'd1);

        // Out-of-range jump target: no refill, no valid data.
        req_log.delete();
        addr_ins  = 16'h8000;
        bad_req   = 0;
        bad_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ddr_rd_req !== 1'b0 || ins_cache_rdy !== 1'b0) bad_req++;
            if (ins_valid !== 1'b0) bad_valid++;
        end
        chk("oor_no_req",   64'(bad_req),              64'd0);
        chk("oor_no_valid", 64'(bad_valid),            64'd0);
        chk("oor_log",      64'(req_log.size()),       64'd0);
        chk("oor_state",    64'(st_cur_ins_cache),     64'd3);
        addr_ins = 16'd3;
        wait_sent("fill0b", 2000);
        check_fill("fill0b", 28'h000);
        chk("fill0b_lt", 64'(load_times), 64'd1);
        tick();
        chk("rd3_out", 64'(ins_out), 64'd3);

        // Jump into the resident page: served without refill.
        req_log.delete();
        addr_ins = 16'd40;
        tick();
        chk("rd40_out",   64'(ins_out),   64'd40);
        chk("rd40_valid", 64'(ins_valid), 64'd1);
        tick();
        chk("rd40_nofill", 64'(req_log.size()), 64'd0);

        // Reset after word 20 of a page 1 fill.
        req_log.delete();
        addr_ins = 16'd100;
        for (int i = 0; i < 1000 && req_log.size() < 21; i++) tick();
        chk("midfill_words", 64'(req_log.size()), 64'd21);
        rst = 1'b1;
        #1;
        reset_checks("midrst");
        tick(); tick();
        req_log.delete();
        addr_ins = 16'd10;
        rst = 1'b0;
        wait_sent("refill", 2000);
        check_fill("refill", 28'h000);
        chk("refill_lt", 64'(load_times), 64'd1);
        tick();
        chk("rd10_out", 64'(ins_out), 64'd10);

        // Random DDR latency, alternate data pattern, spurious strobes in SENT_INS.
        ack_max   = 5;
        data_max  = 5;
        data_mode = 1;
        req_log.delete();
        addr_ins = 16'd70;
        wait_sent("rnd", 3000);
        check_fill("rnd", 28'h200);
        chk("rnd_lt", 64'(load_times), 64'd2);
        addr_ins    = 16'd64;
        ddr_dv_spur = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 64; i++) begin
            addr_ins    = 16'(64 + i);
            ddr_dv_spur = i[0];
            tick();
            chk($sformatf("rnd_word%0d", 64 + i), 64'(ins_out), 64'(ddr_word(64 + i, 1)));
        end
        ddr_dv_spur = 1'b0;
        chk("rnd_valid", 64'(ins_valid),        64'd1);
        chk("rnd_state", 64'(st_cur_ins_cache), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
